fourbit_add_seq: RTL and testbench

- Sequencer that performs one wide addition (4*NSLICE bits) by time-multiplexing a single external 4-bit ripple adder slice with propagation delay (ports A, B, Cin -> Sum, Cout).
- Latches operands on a valid/ready start handshake and presents one nibble per step, LSB first.
- Holds each step's adder inputs stable for a programmable settle window, then captures Sum/Cout and chains the carry.
- Returns the result on a valid/ready result handshake. Sits between the datapath control logic and the shared 4-bit adder.

---
 rtl/fourbit_add_seq.sv | 132 +++++++++++++
 tb/tb_fourbit_add_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fourbit_add_seq.sv
// Wide adder sequencer: time-multiplexes one external 4-bit adder slice, LSB nibble first,
// holding each step's inputs for SETTLE extra cycles before capturing Sum/Cout.
module fourbit_add_seq #(
    parameter int unsigned NSLICE = 4,
    parameter int unsigned SETTLE = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic [4*NSLICE-1:0]   op_a_i,
    input  logic [4*NSLICE-1:0]   op_b_i,
    input  logic                  cin_i,
    output logic [3:0]            add_a_o,
    output logic [3:0]            add_b_o,
    output logic                  add_cin_o,
    input  logic [3:0]            add_sum_i,
    input  logic                  add_cout_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [4*NSLICE-1:0]   result_o,
    output logic                  cout_o,
    output logic                  busy_o
);

    localparam int unsigned W    = 4 * NSLICE;
    localparam int unsigned IdxW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NSLICE - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(SETTLE);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            capture;

    // The adder output is only trusted on the last cycle of a step.
    assign capture = (state_q == StRun) && (cnt_q == CntMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_valid_i) state_d = StRun;
            StRun:   if (capture && (idx_q == IdxLast)) state_d = StDone;
            StDone:  if (res_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_ready_o = (state_q == StIdle);
        busy_o        = (state_q != StIdle);
        res_valid_o   = (state_q == StDone);
        add_a_o       = '0;
        add_b_o       = '0;
        add_cin_o     = 1'b0;
        if (state_q == StRun) begin
            add_a_o   = a_q[4*idx_q +: 4];
            add_b_o   = b_q[4*idx_q +: 4];
            add_cin_o = carry_q;
        end
    end

    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        if ((state_q == StIdle) && start_valid_i) begin
            a_d      = op_a_i;
            b_d      = op_b_i;
            carry_d  = cin_i;
            result_d = '0;
            cout_d   = 1'b0;
            idx_d    = '0;
            cnt_d    = '0;
        end else if (capture) begin
            result_d[4*idx_q +: 4] = add_sum_i;
            carry_d                = add_cout_i;
            cnt_d                  = '0;
            if (idx_q == IdxLast) begin
                cout_d = add_cout_i;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign result_o = result_q;
    assign cout_o   = cout_q;

endmodule

// File: tb/tb_fourbit_add_seq.sv
// Bench for fourbit_add_seq: delayed glitchy adder model, scoreboard on the result handshake,
// directed corner cases plus randomized operations, and a SETTLE=0/NSLICE=2 variant.
module tb_fourbit_add_seq;

    localparam int NS  = 4;
    localparam int ST  = 3;
    localparam int LAT = NS * (ST + 1);

    typedef struct packed {
        logic [15:0] res;
        logic        co;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid, start_ready, cin, res_valid, res_ready, cout, busy;
    logic [15:0] op_a, op_b, result;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    logic        p2_start_valid, p2_start_ready, p2_cin, p2_res_valid, p2_res_ready;
    logic        p2_cout, p2_busy, p2_add_cin, p2_add_cout;
    logic [7:0]  p2_op_a, p2_op_b, p2_result;
    logic [3:0]  p2_add_a, p2_add_b, p2_add_sum;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    fourbit_add_seq #(.NSLICE(NS), .SETTLE(ST)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .start_valid_i(start_valid), .start_ready_o(start_ready),
        .op_a_i(op_a), .op_b_i(op_b), .cin_i(cin),
        .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
        .add_sum_i(add_sum), .add_cout_i(add_cout),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .result_o(result), .cout_o(cout), .busy_o(busy)
    );

    fourbit_add_seq #(.NSLICE(2), .SETTLE(0)) dut_p2 (
        .clk_i(clk), .rst_ni(rst_n),
        .start_valid_i(p2_start_valid), .start_ready_o(p2_start_ready),
        .op_a_i(p2_op_a), .op_b_i(p2_op_b), .cin_i(p2_cin),
        .add_a_o(p2_add_a), .add_b_o(p2_add_b), .add_cin_o(p2_add_cin),
        .add_sum_i(p2_add_sum), .add_cout_i(p2_add_cout),
        .res_valid_o(p2_res_valid), .res_ready_i(p2_res_ready),
        .result_o(p2_result), .cout_o(p2_cout), .busy_o(p2_busy)
    );

    // Slow adder: garbage right after any input change, correct value 8 ns later.
    always begin
        {add_cout, add_sum} = 5'($urandom);
        #8;
        {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);
        @(add_a or add_b or add_cin);
    end

    assign {p2_add_cout, p2_add_sum} = 5'(p2_add_a) + 5'(p2_add_b) + 5'(p2_add_cin);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares on every cycle where the result handshake will complete.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(res_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("cout", 32'(cout), 32'(e.co));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'(1));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        chk({tag, "_result"}, 32'(result), 32'(0));
        chk({tag, "_cout"}, 32'(cout), 32'(0));
        chk({tag, "_add_bus"}, 32'({add_a, add_b, add_cin}), 32'(0));
    endtask

    // One operation on the main DUT; pulse_at/abort_at are cycle offsets after accept (-1 = off).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input int ready_delay, input int pulse_at, input int abort_at);
        logic [16:0] full;
        int unsigned s, mask, exp_c;
        int waited = 0;
        exp_t e;
        full = 17'(a) + 17'(b) + 17'(ci);
        @(negedge clk);
        while (!start_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!start_ready) begin
            chk("idle_timeout", 32'(start_ready), 32'(1));
            return;
        end
        @(posedge clk);
        #2;
        start_valid = 1'b1;
        op_a = a; op_b = b; cin = ci;
        @(posedge clk);
        e.res = full[15:0];
        e.co  = full[16];
        sb.push_back(e);
        #2;
        start_valid = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            s     = k / (ST + 1);
            mask  = (32'd1 << (4 * s)) - 1;
            exp_c = (((a & mask) + (b & mask) + ci) >> (4 * s)) & 1;
            chk("slice_add_a", 32'(add_a), (32'(a) >> (4 * s)) & 32'hF);
            chk("slice_add_b", 32'(add_b), (32'(b) >> (4 * s)) & 32'hF);
            chk("slice_add_cin", 32'(add_cin), exp_c);
            chk("run_flags", 32'({busy, start_ready, res_valid}), 32'b100);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                sb.delete();
                chk_reset_outputs("abort");
                @(negedge clk);
                chk_reset_outputs("abort_held");
                rst_n = 1'b1;
                return;
            end
            if (k == pulse_at) begin
                start_valid = 1'b1;
                op_a = 16'h1111; op_b = 16'h1111;
            end else if (k == pulse_at + 1) begin
                start_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("latency_res_valid", 32'(res_valid), 32'(1));
        for (int d = 0; d < ready_delay; d++) begin
            chk("held_result", 32'({cout, result}), 32'(full));
            chk("held_flags", 32'({busy, start_ready, res_valid}), 32'b101);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        @(posedge clk);
        #2;
        res_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_ack", 32'({busy, start_ready, res_valid}), 32'b010);
    endtask

    task automatic p2_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] full;
        full = 9'(a) + 9'(b) + 9'(ci);
        @(posedge clk);
        #2;
        p2_start_valid = 1'b1;
        p2_op_a = a; p2_op_b = b; p2_cin = ci;
        @(posedge clk);
        #2;
        p2_start_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("p2_add_a", 32'(p2_add_a), (32'(a) >> (4 * k)) & 32'hF);
            chk("p2_add_cin", 32'(p2_add_cin),
                k == 0 ? 32'(ci) : ((32'(a & 8'hF) + 32'(b & 8'hF) + 32'(ci)) >> 4));
            chk("p2_res_valid_low", 32'(p2_res_valid), 32'(0));
        end
        @(negedge clk);
        chk("p2_latency", 32'(p2_res_valid), 32'(1));
        chk("p2_result", 32'({p2_cout, p2_result}), 32'(full));
        @(posedge clk);
        #2;
        p2_res_ready = 1'b1;
        @(posedge clk);
        #2;
        p2_res_ready = 1'b0;
        @(negedge clk);
        chk("p2_idle", 32'({p2_busy, p2_start_ready}), 32'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0; res_ready = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        p2_start_valid = 1'b0; p2_res_ready = 1'b0; p2_op_a = '0; p2_op_b = '0; p2_cin = 1'b0;
        #17;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, -1, -1);
        run_op(16'h1234, 16'h4321, 1'b1, 0, -1, -1);
        run_op(16'hC00C, 16'h3003, 1'b0, 5, -1, -1);
        run_op(16'h2222, 16'h3333, 1'b0, 1, 4, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_queued_run", 32'({busy, res_valid}), 32'b00);
        end
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, -1, 7);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), -1, -1);
        end

        p2_op(8'hFF, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            p2_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
